// File: rtl/div_operand_sequencer.sv
// Operand feeder for the serial divider: serialises dividend-hi, dividend-lo and divisor words, then
// waits for done under a watchdog and presents quotient/remainder/flags downstream via valid/ready.
module div_operand_sequencer #(
    parameter int DW      = 5,
    parameter int TIMEOUT = 63
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [2*DW-1:0] in_dividend_i,
    input  logic [DW-1:0]   in_divisor_i,
    output logic            div_start_o,
    output logic [DW-1:0]   div_data_o,
    input  logic            div_done_i,
    input  logic            div_ov_i,
    input  logic            div_dbz_i,
    input  logic [DW-1:0]   div_result_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [DW-1:0]   out_quotient_o,
    output logic [DW-1:0]   out_remainder_o,
    output logic            out_ov_o,
    output logic            out_dbz_o,
    output logic            out_timeout_o
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] WDOG_LAST = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] WDOG_MAX  = {CW{1'b1}};

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_SEND_HI  = 3'd1,
        S_SEND_LO  = 3'd2,
        S_SEND_DIV = 3'd3,
        S_WAIT     = 3'd4,
        S_CAP_REM  = 3'd5,
        S_RESP     = 3'd6
    } state_t;

    state_t            state_q, state_d;
    logic [2*DW-1:0]   dividend_q, dividend_d;
    logic [DW-1:0]     divisor_q, divisor_d;
    logic [CW-1:0]     wdog_q, wdog_d;
    logic [DW-1:0]     quot_q, quot_d;
    logic [DW-1:0]     rem_q, rem_d;
    logic              ov_q, ov_d;
    logic              dbz_q, dbz_d;
    logic              tmo_q, tmo_d;

    logic              accept;
    logic              result_taken;
    logic              wdog_expired;
    logic              done_flagged;

    assign accept       = (state_q == S_IDLE) && in_valid_i;
    assign result_taken = (state_q == S_RESP) && out_ready_i;
    assign wdog_expired = (wdog_q == WDOG_LAST);
    assign done_flagged = div_ov_i || div_dbz_i;

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = S_SEND_HI;
                end
            end
            S_SEND_HI:  state_d = S_SEND_LO;
            S_SEND_LO:  state_d = S_SEND_DIV;
            S_SEND_DIV: state_d = S_WAIT;
            S_WAIT: begin
                // done wins over a watchdog expiry landing in the same cycle
                if (div_done_i) begin
                    state_d = done_flagged ? S_RESP : S_CAP_REM;
                end else if (wdog_expired) begin
                    state_d = S_RESP;
                end
            end
            S_CAP_REM:  state_d = S_RESP;
            S_RESP: begin
                if (result_taken) begin
                    state_d = S_IDLE;
                end
            end
            default:    state_d = S_IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        in_ready_o  = 1'b0;
        div_start_o = 1'b0;
        div_data_o  = '0;
        out_valid_o = 1'b0;
        case (state_q)
            S_IDLE:     in_ready_o = 1'b1;
            S_SEND_HI: begin
                div_start_o = 1'b1;
                div_data_o  = dividend_q[2*DW-1:DW];
            end
            S_SEND_LO:  div_data_o = dividend_q[DW-1:0];
            S_SEND_DIV: div_data_o = divisor_q;
            S_RESP:     out_valid_o = 1'b1;
            default: begin
                in_ready_o  = 1'b0;
                div_start_o = 1'b0;
            end
        endcase
    end

    assign out_quotient_o  = quot_q;
    assign out_remainder_o = rem_q;
    assign out_ov_o        = ov_q;
    assign out_dbz_o       = dbz_q;
    assign out_timeout_o   = tmo_q;

    // Datapath next-state: operand latch, watchdog and result capture
    always_comb begin
        dividend_d = dividend_q;
        divisor_d  = divisor_q;
        wdog_d     = wdog_q;
        quot_d     = quot_q;
        rem_d      = rem_q;
        ov_d       = ov_q;
        dbz_d      = dbz_q;
        tmo_d      = tmo_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    dividend_d = in_dividend_i;
                    divisor_d  = in_divisor_i;
                end
            end
            S_SEND_DIV: begin
                wdog_d = '0;
            end
            S_WAIT: begin
                if (wdog_q != WDOG_MAX) begin
                    wdog_d = wdog_q + CW'(1);
                end
                if (div_done_i) begin
                    quot_d = done_flagged ? '0 : div_result_i;
                    rem_d  = '0;
                    ov_d   = div_ov_i;
                    dbz_d  = div_dbz_i;
                    tmo_d  = 1'b0;
                end else if (wdog_expired) begin
                    quot_d = {DW{1'b1}};
                    rem_d  = {DW{1'b1}};
                    ov_d   = 1'b0;
                    dbz_d  = 1'b0;
                    tmo_d  = 1'b1;
                end
            end
            S_CAP_REM: begin
                rem_d = div_result_i;
            end
            S_RESP: begin
                if (result_taken) begin
                    quot_d = '0;
                    rem_d  = '0;
                    ov_d   = 1'b0;
                    dbz_d  = 1'b0;
                    tmo_d  = 1'b0;
                end
            end
            default: begin
                wdog_d = wdog_q;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            dividend_q <= '0;
            divisor_q  <= '0;
            wdog_q     <= '0;
            quot_q     <= '0;
            rem_q      <= '0;
            ov_q       <= 1'b0;
            dbz_q      <= 1'b0;
            tmo_q      <= 1'b0;
        end else begin
            dividend_q <= dividend_d;
            divisor_q  <= divisor_d;
            wdog_q     <= wdog_d;
            quot_q     <= quot_d;
            rem_q      <= rem_d;
            ov_q       <= ov_d;
            dbz_q      <= dbz_d;
            tmo_q      <= tmo_d;
        end
    end

endmodule
